// File: rtl/multadd_seq.sv
// rtl/multadd_seq.sv - sequential shift-add multiply-add, y = ((x1*x2) >> FRAC) + x3
module multadd_seq #(
  parameter int WIDTH    = 10,
  parameter int FRAC     = 0,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] x3_q, x3_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [AW:0]      sum;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    x3_d     = x3_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    // One extra bit so the carry out of the add is visible for overflow detection
    sum = {1'b0, (acc_q >> FRAC)} + {{(WIDTH + 1){1'b0}}, x3_q};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, x1};
          mplier_d = x2;
          x3_d     = x3;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MULT;
        end else begin
          state_d  = IDLE;
        end
      end
      MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ADD;
      end
      ADD: begin
        ovf_d   = |sum[AW:WIDTH];
        y_d     = (ovf_d && (SATURATE != 0)) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MULT) || (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      x3_q     <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      x3_q     <= x3_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_multadd_seq.sv
// tb/tb_multadd_seq.sv - self-checking bench for multadd_seq in three parameterisations
module tb_multadd_seq;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x1 = '0, x2 = '0, x3 = '0;
  logic [2:0]   busy_v, done_v, ovf_v;
  logic [2:0][W-1:0] y_v;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  // u_sat: FRAC=0 saturating; u_wrap: FRAC=0 wrapping; u_frac: FRAC=4 saturating
  multadd_seq #(.WIDTH(W), .FRAC(0), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]), .ovf(ovf_v[0]));
  multadd_seq #(.WIDTH(W), .FRAC(0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]), .ovf(ovf_v[1]));
  multadd_seq #(.WIDTH(W), .FRAC(4), .SATURATE(1)) u_frac (
    .clk(clk), .reset_n(reset_n), .start(start), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_v[2]), .done(done_v[2]), .y(y_v[2]), .ovf(ovf_v[2]));

  function automatic int frac_of(input int i);
    return (i == 2) ? 4 : 0;
  endfunction

  function automatic bit sat_of(input int i);
    return (i != 1);
  endfunction

  // Returns {ovf, y} from plain integer arithmetic
  function automatic logic [W:0] ref_result(input int i, input logic [W-1:0] a, b, c);
    longint s;
    logic   o;
    s = ((longint'(a) * longint'(b)) >> frac_of(i)) + longint'(c);
    o = (s >= (longint'(1) << W));
    if (o && sat_of(i)) return {1'b1, {W{1'b1}}};
    return {o, W'(s)};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timing model: an accepted op completes W+1 edges later; result appears with done
  int                rem = 0;
  bit                m_done = 1'b0;
  logic [W-1:0]      p1 = '0, p2 = '0, p3 = '0;
  logic [2:0][W-1:0] m_y = '0;
  logic [2:0]        m_ovf = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem    <= 0;
      m_done <= 1'b0;
      m_y    <= '0;
      m_ovf  <= '0;
    end else if (rem > 0) begin
      rem    <= rem - 1;
      m_done <= (rem == 1);
      if (rem == 1)
        for (int i = 0; i < 3; i++) {m_ovf[i], m_y[i]} <= ref_result(i, p1, p2, p3);
    end else begin
      m_done <= 1'b0;
      if (start) begin
        p1  <= x1;
        p2  <= x2;
        p3  <= x3;
        rem <= W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d_busy", i), busy_v[i], (rem != 0));
        check($sformatf("u%0d_done", i), done_v[i], m_done);
        check($sformatf("u%0d_y", i), y_v[i], m_y[i]);
        check($sformatf("u%0d_ovf", i), ovf_v[i], m_ovf[i]);
        check($sformatf("u%0d_done_busy_excl", i), done_v[i] & busy_v[i], 0);
      end
    end
  end

  task automatic op(input logic [W-1:0] a, b, c, input bit scramble,
                    output int edges, output int bcyc);
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin x1 = '1; x2 = '1; x3 = '1; end
    edges = 1;
    bcyc  = busy_v[0] ? 1 : 0;
    while (!done_v[0] && edges < 40) begin
      @(negedge clk);
      edges++;
      if (busy_v[0]) bcyc++;
    end
    check("op_timeout", (edges < 40), 1);
  endtask

  typedef struct {
    logic [W-1:0] a, b, c, y;
    logic         o;
  } vec_t;

  vec_t vecs[6] = '{
    '{10'h000, 10'h000, 10'h000, 10'h000, 1'b0},
    '{10'h000, 10'h3FF, 10'h155, 10'h155, 1'b0},
    '{10'h3FF, 10'h001, 10'h000, 10'h3FF, 1'b0},
    '{10'h01F, 10'h020, 10'h01F, 10'h3FF, 1'b0},
    '{10'h020, 10'h020, 10'h000, 10'h3FF, 1'b1},
    '{10'h00C, 10'h00D, 10'h064, 10'h100, 1'b0}
  };

  initial begin
    int edges, bcyc, dcnt;

    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check("rst_y", y_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_ovf", ovf_v[0], 0);
    reset_n = 1'b1;

    // 1: basic op, latency and busy length
    op(10'h003, 10'h005, 10'h007, 1'b0, edges, bcyc);
    check("t1_latency", edges, 12);
    check("t1_busy_cycles", bcyc, 11);
    check("t1_y", y_v[0], 10'h016);
    check("t1_ovf", ovf_v[0], 0);
    check("t1_model_y", m_y[0], 10'h016);
    check("t1_frac_y", y_v[2], 10'h007);

    // 2: overflow, saturate vs wrap
    op(10'h3FF, 10'h3FF, 10'h001, 1'b0, edges, bcyc);
    check("t2_sat_y", y_v[0], 10'h3FF);
    check("t2_sat_ovf", ovf_v[0], 1);
    check("t2_wrap_y", y_v[1], 10'h002);
    check("t2_wrap_ovf", ovf_v[1], 1);
    check("t2_model_wrap_y", m_y[1], 10'h002);

    // 3: operand changes during MULT have no effect
    op(10'h004, 10'h006, 10'h002, 1'b1, edges, bcyc);
    check("t3_y", y_v[0], 10'h01A);
    check("t3_ovf", ovf_v[0], 0);

    // 4: start held high -> back-to-back ops, one done per op
    @(negedge clk);
    x1 = 10'h003; x2 = 10'h005; x3 = 10'h007; start = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_v[0]) dcnt++;
    end
    start = 1'b0;
    check("t4_done_pulses_held", dcnt, 2);
    dcnt = 0;
    for (int k = 0; k < 20 && dcnt == 0; k++) begin
      @(negedge clk);
      if (done_v[0]) dcnt++;
    end
    check("t4_done_tail", dcnt, 1);
    check("t4_y", y_v[0], 10'h016);

    // 5: reset mid-MULT abandons the op
    @(negedge clk);
    x1 = 10'h003; x2 = 10'h005; x3 = 10'h007; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_y", y_v[0], 0);
    check("t5_rst_busy", busy_v[0], 0);
    check("t5_rst_done", done_v[0], 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    op(10'h003, 10'h005, 10'h007, 1'b0, edges, bcyc);
    check("t5_after_y", y_v[0], 10'h016);
    check("t5_after_latency", edges, 12);

    // 6: fixed-point scaling, 2.0*3.0+1.0 in Q4
    op(10'h020, 10'h030, 10'h010, 1'b0, edges, bcyc);
    check("t6_frac_y", y_v[2], 10'h070);
    check("t6_frac_ovf", ovf_v[2], 0);
    check("t6_wrap_y", y_v[1], 10'h210);

    // Vector table for the saturating FRAC=0 instance
    foreach (vecs[v]) begin
      op(vecs[v].a, vecs[v].b, vecs[v].c, 1'b0, edges, bcyc);
      check($sformatf("vec%0d_y", v), y_v[0], vecs[v].y);
      check($sformatf("vec%0d_ovf", v), ovf_v[0], vecs[v].o);
    end

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
